// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer: steers mapper writes into two external banks and drains full banks to the FFT in fill order.
// Optional build macro PPC_DROP_CNT_EN adds a saturating drop_cnt output counting overflow pulses.
module pingpong_bank_ctrl #(
  parameter int MEM_DEPTH = 1200,
  parameter int ADDR_W    = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_valid,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_we,
  input  logic              rd_busy,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_first,
  output logic              rd_last,
  output logic [1:0]        bank_full,
  output logic              overflow
`ifdef PPC_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } bank_state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic [ADDR_W-1:0] len_q   [2];
  logic [ADDR_W-1:0] len_d   [2];
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_active_q, rd_active_d;

  logic wr_accept;
  logic wr_end;
  logic rd_start;
  logic rd_final;

  // State register process.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: the two length registers are real flops, not RAM, so they are cleared like any other state.
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= ST_EMPTY;
        len_q[b]   <= '0;
      end
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_active_q <= rd_active_d;
    end
  end

  // Next-state process. Write and read sides never touch the same bank in one cycle:
  // writes target EMPTY/FILL banks, reads target FULL/DRAIN banks.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    len_d       = len_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    rd_active_d = rd_active_q;

    wr_accept = wr_valid && (state_q[wr_bank_q] == ST_EMPTY || state_q[wr_bank_q] == ST_FILL);
    wr_end    = wr_accept && (wr_last || wr_addr_q == LAST_ADDR);
    rd_start  = !rd_active_q && state_q[rd_bank_q] == ST_FULL && !rd_busy;
    rd_final  = rd_active_q && rd_addr_q == len_q[rd_bank_q] - 1'b1;

    if (wr_accept) begin
      if (wr_end) begin
        state_d[wr_bank_q] = ST_FULL;
        len_d[wr_bank_q]   = wr_addr_q + 1'b1;
        wr_bank_d          = ~wr_bank_q;
        wr_addr_d          = '0;
      end else begin
        state_d[wr_bank_q] = ST_FILL;
        wr_addr_d          = wr_addr_q + 1'b1;
      end
    end

    if (rd_start) begin
      state_d[rd_bank_q] = ST_DRAIN;
      rd_active_d        = 1'b1;
      rd_addr_d          = '0;
    end else if (rd_active_q) begin
      if (rd_final) begin
        state_d[rd_bank_q] = ST_EMPTY;
        rd_bank_d          = ~rd_bank_q;
        rd_active_d        = 1'b0;
        rd_addr_d          = '0;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
  end

  // Output process: everything except the wr_valid-qualified strobes comes from registers only.
  always_comb begin
    wr_ready  = state_q[wr_bank_q] == ST_EMPTY || state_q[wr_bank_q] == ST_FILL;
    wr_we     = wr_valid && wr_ready;
    overflow  = wr_valid && !wr_ready;
    wr_bank   = wr_bank_q;
    wr_addr   = wr_addr_q;
    rd_en     = rd_active_q;
    rd_bank   = rd_bank_q;
    rd_addr   = rd_addr_q;
    rd_first  = rd_active_q && rd_addr_q == '0;
    rd_last   = rd_final;
    for (int b = 0; b < 2; b++) begin
      bank_full[b] = state_q[b] == ST_FULL || state_q[b] == ST_DRAIN;
    end
  end

`ifdef PPC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Scoreboard bench for pingpong_bank_ctrl: a symbol-level model predicts write-side behaviour and queues expected read beats.
module tb_pingpong_bank_ctrl;
  localparam int MEM_DEPTH = 1200;
  localparam int ADDR_W    = 11;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              wr_valid = 1'b0, wr_last = 1'b0, rd_busy = 1'b0;
  logic              wr_ready, wr_bank, wr_we;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              rd_en, rd_bank, rd_first, rd_last, overflow;
  logic [1:0]        bank_full;
`ifdef PPC_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  pingpong_bank_ctrl #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_we(wr_we),
    .rd_busy(rd_busy), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_first(rd_first), .rd_last(rd_last), .bank_full(bank_full),
    .overflow(overflow)
`ifdef PPC_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit bank;
    int addr;
    bit first;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Symbol-level model: which banks hold an unread symbol, and where the writer is.
  bit m_occ[2];
  bit free_pend[2];
  bit m_wr_bank;
  int m_wr_addr;
  int m_drops;
  int m_accepts;
  int ovf_seen;
  int cyc = 0;
  int end_cyc = 0;
  int first_cyc = 0;
  int rd_beats = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_occ     = '{0, 0};
    free_pend = '{0, 0};
    m_wr_bank = 1'b0;
    m_wr_addr = 0;
    m_drops   = 0;
    ovf_seen  = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input bit v, input bit l, input bit b);
    bit exp_ready, accept, endsym;
    int len;
    wr_valid = v;
    wr_last  = l;
    rd_busy  = b;
    @(negedge CLK);
    exp_ready = !m_occ[m_wr_bank];
    check("wr_ready", wr_ready, exp_ready);
    check("wr_we", wr_we, v && exp_ready);
    check("overflow", overflow, v && !exp_ready);
    check("wr_bank", wr_bank, m_wr_bank);
    check("wr_addr", wr_addr, m_wr_addr);
    check("bank_full", bank_full, {m_occ[1], m_occ[0]});
    if (overflow === 1'b1) ovf_seen++;
    accept = v && exp_ready;
    endsym = accept && (l || m_wr_addr == MEM_DEPTH - 1);
    if (endsym) end_cyc = cyc;
    if (v && !exp_ready) m_drops++;
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (free_pend[i]) begin
        m_occ[i]     = 1'b0;
        free_pend[i] = 1'b0;
      end
    end
    if (accept) begin
      m_accepts++;
      if (endsym) begin
        len = m_wr_addr + 1;
        for (int a = 0; a < len; a++) exp_q.push_back('{m_wr_bank, a, a == 0, a == len - 1});
        m_occ[m_wr_bank] = 1'b1;
        m_wr_bank = ~m_wr_bank;
        m_wr_addr = 0;
      end else begin
        m_wr_addr++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RST      = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_busy  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    RST = 1'b1;
    @(negedge CLK);
    check("reset_wr_ready", wr_ready, 1);
    check("reset_outputs",
          {wr_bank, wr_addr, wr_we, rd_en, rd_bank, rd_addr, rd_first, rd_last, bank_full, overflow}, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic write_symbol(input int len, input bit busy);
    for (int i = 0; i < len; i++) cycle(1'b1, i == len - 1, busy);
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !m_occ[0] && !m_occ[1]) begin
        done = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("drain_complete", done, 1);
  endtask

  // Read-side monitor: pops one expected beat per rd_en.
  bit busy_prev = 1'b0;
  bit in_drain  = 1'b0;
  always @(negedge CLK) begin
    beat_t e;
    if (!RST) begin
      exp_q.delete();
      in_drain  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (in_drain) check("rd_en_contiguous", rd_en, 1);
      if (rd_en === 1'b1) begin
        rd_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got rd_en=1 addr %0d, expected no read (cycle %0d)", rd_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rd_bank", rd_bank, e.bank);
          check("rd_addr", rd_addr, e.addr);
          check("rd_first", rd_first, e.first);
          check("rd_last", rd_last, e.last);
          if (e.first) begin
            check("start_while_busy", busy_prev, 0);
            first_cyc = cyc;
          end
          in_drain = !e.last;
          if (e.last) free_pend[e.bank] = 1'b1;
        end
      end else begin
        check("rd_strobes_idle", {rd_first, rd_last}, 0);
      end
      busy_prev = rd_busy;
    end
  end

  initial begin
    int base;
    @(posedge CLK);
    #1;
    model_reset();
    m_accepts = 0;
    do_reset();

    // 12-sample symbol, earliest drain latency.
    base = rd_beats;
    write_symbol(12, 1'b0);
    wait_drain(100);
    check("t1_beats", rd_beats - base, 12);
    check("t1_latency", first_cyc - end_cyc, 2);

    // Three auto-terminated 1200-sample symbols; the writer only offers when ready.
    base = m_accepts;
    for (int i = 0; i < 6000 && m_accepts - base < 3 * MEM_DEPTH; i++) begin
      cycle(!m_occ[m_wr_bank], 1'b0, 1'b0);
    end
    check("t2_accepted", m_accepts - base, 3 * MEM_DEPTH);
    wait_drain(3000);

    // FFT held busy: third symbol has nowhere to go.
    do_reset();
    for (int s = 0; s < 3; s++) write_symbol(8, 1'b1);
    check("t3_overflow_pulses", ovf_seen, 8);
`ifdef PPC_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt, m_drops);
`endif
    wait_drain(100);

    // Busy raised on the third beat of a drain; the next drain must wait.
    write_symbol(10, 1'b1);
    write_symbol(6, 1'b1);
    base = rd_beats;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, (rd_beats - base) >= 2);
    check("t4_first_drain_beats", rd_beats - base, 10);
    check("t4_second_waits", exp_q.size(), 6);
    wait_drain(100);

    // Single-sample symbol, then reset in the middle of a 100-sample fill.
    write_symbol(1, 1'b0);
    wait_drain(50);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    write_symbol(5, 1'b0);
    wait_drain(50);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
    end
`ifdef PPC_DROP_CNT_EN
    check("rand_drop_cnt", drop_cnt, (m_drops > 16'hFFFF) ? 16'hFFFF : m_drops);
`endif
    wait_drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
